// File: rtl/fire_arbiter_pkg.sv
// Shared definitions for the launch arbiter: FSM encodings, default parameters
// and the index-width helper used by the arbiter and its round-robin picker.
package fire_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE     = 2'b00;
    localparam arb_state_t ST_LAUNCH   = 2'b01;
    localparam arb_state_t ST_COOLDOWN = 2'b10;
    localparam arb_state_t ST_EMPTY    = 2'b11;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_MAG_SIZE = 4;
    localparam int DEF_COOLDOWN = 10;

    // Magazine count is a fixed 4-bit field on the launcher interface.
    localparam int MAG_W = 4;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fire_arbiter_rr_picker.sv
// Combinational round-robin selector: first eligible channel at or after
// rr_ptr, wrapping at NUM_CH.
module rr_picker
    import fire_arbiter_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int CH_W   = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] elig,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   index,
    output logic              valid
);

    always_comb begin
        int k;
        // NOTE: every output gets a default before the loop so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        k     = 0;
        grant = '0;
        index = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_CH) begin
                k = k - NUM_CH;
            end
            if (!valid && elig[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                index    = CH_W'(k);
            end
        end
    end

endmodule

// File: rtl/fire_arbiter.sv
// Launch arbiter: grants the single launcher to one locked channel at a time,
// enforces a post-launch cooldown and tracks the magazine. Defining
// FIRE_ARB_RELOAD_EN adds the reload port; otherwise EMPTY holds until rst.
module fire_arbiter
    import fire_arbiter_pkg::*;
#(
    parameter  int NUM_CH   = DEF_NUM_CH,
    parameter  int MAG_SIZE = DEF_MAG_SIZE,
    parameter  int COOLDOWN = DEF_COOLDOWN,
    localparam int CH_W     = idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] target_locked,
    input  logic [NUM_CH-1:0] fire_req,
`ifdef FIRE_ARB_RELOAD_EN
    input  logic              reload,
`endif
    output logic [NUM_CH-1:0] fire_grant,
    output logic              launch_missile,
    output logic [CH_W-1:0]   launch_ch,
    output logic              fire_denied,
    output logic [MAG_W-1:0]  remaining_missiles,
    output logic [1:0]        arb_state
);

    localparam int               CNT_W    = idx_w(COOLDOWN);
    localparam logic [MAG_W-1:0] MAG_INIT = MAG_W'(MAG_SIZE);
    localparam logic [CNT_W-1:0] CD_INIT  = CNT_W'(COOLDOWN - 1);

    arb_state_t        state_q, state_d;
    logic [MAG_W-1:0]  rem_q, rem_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   launch_ch_q, launch_ch_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              launch_q, launch_d;
    logic              denied_q, denied_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] pick_grant;
    logic [CH_W-1:0]   pick_index;
    logic              pick_valid;
    logic              reload_w;

    assign elig = fire_req & target_locked;

`ifdef FIRE_ARB_RELOAD_EN
    assign reload_w = reload;
`else
    assign reload_w = 1'b0;
`endif

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_rr_picker (
        .elig   (elig),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .index  (pick_index),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        rr_ptr_d    = rr_ptr_q;
        launch_ch_d = launch_ch_q;
        cnt_d       = cnt_q;
        grant_d     = '0;
        launch_d    = 1'b0;
        denied_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Reload wins over a pending request; the launch waits a cycle.
                if (reload_w) begin
                    rem_d = MAG_INIT;
                end else if (rem_q == '0) begin
                    state_d = ST_EMPTY;
                end else if (pick_valid) begin
                    grant_d     = pick_grant;
                    launch_ch_d = pick_index;
                    launch_d    = 1'b1;
                    rem_d       = rem_q - MAG_W'(1);
                    state_d     = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                rr_ptr_d = (launch_ch_q == CH_W'(NUM_CH - 1)) ? '0
                                                              : launch_ch_q + CH_W'(1);
                cnt_d    = CD_INIT;
                state_d  = ST_COOLDOWN;
            end

            ST_COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = (rem_q == '0) ? ST_EMPTY : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_EMPTY: begin
                denied_d = |elig;
                if (reload_w) begin
                    rem_d   = MAG_INIT;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= MAG_INIT;
            rr_ptr_q    <= '0;
            launch_ch_q <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            launch_q    <= 1'b0;
            denied_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            rr_ptr_q    <= rr_ptr_d;
            launch_ch_q <= launch_ch_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            launch_q    <= launch_d;
            denied_q    <= denied_d;
        end
    end

    assign fire_grant         = grant_q;
    assign launch_missile     = launch_q;
    assign launch_ch          = launch_ch_q;
    assign fire_denied        = denied_q;
    assign remaining_missiles = rem_q;
    assign arb_state          = state_q;

endmodule

// File: tb/tb_fire_arbiter.sv
// Directed bench for fire_arbiter with default parameters (4 channels,
// magazine 4, cooldown 10); inputs change and outputs are sampled on negedge.
module tb_fire_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] target_locked = 4'b0000;
    logic [3:0] fire_req = 4'b0000;
`ifdef FIRE_ARB_RELOAD_EN
    logic       reload = 1'b0;
`endif
    logic [3:0] fire_grant;
    logic       launch_missile;
    logic [1:0] launch_ch;
    logic       fire_denied;
    logic [3:0] remaining_missiles;
    logic [1:0] arb_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fire_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .target_locked      (target_locked),
        .fire_req           (fire_req),
`ifdef FIRE_ARB_RELOAD_EN
        .reload             (reload),
`endif
        .fire_grant         (fire_grant),
        .launch_missile     (launch_missile),
        .launch_ch          (launch_ch),
        .fire_denied        (fire_denied),
        .remaining_missiles (remaining_missiles),
        .arb_state          (arb_state)
    );

    // {state, launch, grant, ch, remaining, denied}
    function automatic logic [13:0] snap();
        return {arb_state, launch_missile, fire_grant, launch_ch, remaining_missiles, fire_denied};
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        fire_req      = 4'b0000;
        target_locked = 4'b0000;
`ifdef FIRE_ARB_RELOAD_EN
        reload        = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (arb_state !== 2'b00) begin
            n_err++; $display("FAIL reset_state: got %b expected 00", arb_state);
        end
        n_vec++;
        if (remaining_missiles !== 4'd4) begin
            n_err++; $display("FAIL reset_remaining: got %0d expected 4", remaining_missiles);
        end
        n_vec++;
        if (fire_grant !== 4'b0000) begin
            n_err++; $display("FAIL reset_grant: got %b expected 0000", fire_grant);
        end
        n_vec++;
        if (launch_missile !== 1'b0) begin
            n_err++; $display("FAIL reset_launch: got %b expected 0", launch_missile);
        end
        n_vec++;
        if (launch_ch !== 2'd0) begin
            n_err++; $display("FAIL reset_launch_ch: got %0d expected 0", launch_ch);
        end
        n_vec++;
        if (fire_denied !== 1'b0) begin
            n_err++; $display("FAIL reset_denied: got %b expected 0", fire_denied);
        end
    endtask

    task automatic test_single_launch();
        do_reset();
        fire_req      = 4'b0010;
        target_locked = 4'b0010;
        @(negedge clk);
        fire_req      = 4'b0000;
        target_locked = 4'b0000;
        n_vec++;
        if (snap() !== {2'b01, 1'b1, 4'b0010, 2'd1, 4'd3, 1'b0}) begin
            n_err++; $display("FAIL single_launch: got %b expected %b", snap(),
                              {2'b01, 1'b1, 4'b0010, 2'd1, 4'd3, 1'b0});
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (snap() !== {2'b10, 1'b0, 4'b0000, 2'd1, 4'd3, 1'b0}) begin
                n_err++; $display("FAIL single_cooldown[%0d]: got %b expected %b", i, snap(),
                                  {2'b10, 1'b0, 4'b0000, 2'd1, 4'd3, 1'b0});
            end
        end
        @(negedge clk);
        n_vec++;
        if (snap() !== {2'b00, 1'b0, 4'b0000, 2'd1, 4'd3, 1'b0}) begin
            n_err++; $display("FAIL single_back_idle: got %b expected %b", snap(),
                              {2'b00, 1'b0, 4'b0000, 2'd1, 4'd3, 1'b0});
        end
    endtask

    // Channels 0 and 2 held: grants 0,2,0,2 every 12 cycles, then EMPTY with denials.
    task automatic test_round_robin_to_empty();
        logic [1:0]  es;
        logic        el;
        logic [3:0]  eg;
        logic [1:0]  ec;
        logic [3:0]  er;
        logic        ed;
        int          k;
        int          r;
        do_reset();
        fire_req      = 4'b0101;
        target_locked = 4'b0101;
        for (int t = 0; t <= 52; t++) begin
            @(negedge clk);
            k  = (t / 12 > 3) ? 3 : t / 12;
            r  = t % 12;
            el = (t <= 36) && (r == 0);
            if (t >= 47)      es = 2'b11;
            else if (r == 0)  es = 2'b01;
            else if (r == 11) es = 2'b00;
            else              es = 2'b10;
            ec = (k % 2 == 0) ? 2'd0 : 2'd2;
            eg = el ? ((k % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0000;
            er = (t >= 36) ? 4'd0 : 4'(3 - k);
            ed = (t >= 48);
            n_vec++;
            if (snap() !== {es, el, eg, ec, er, ed}) begin
                n_err++; $display("FAIL rr_cycle[%0d]: got %b expected %b", t, snap(),
                                  {es, el, eg, ec, er, ed});
            end
        end
        // Request without lock in EMPTY is not a denial.
        target_locked = 4'b0000;
        @(negedge clk);
        n_vec++;
        if ({arb_state, fire_denied, remaining_missiles} !== {2'b11, 1'b0, 4'd0}) begin
            n_err++; $display("FAIL empty_unlocked: got %b expected %b",
                              {arb_state, fire_denied, remaining_missiles}, {2'b11, 1'b0, 4'd0});
        end
    endtask

    task automatic test_unlocked_requests();
        do_reset();
        fire_req      = 4'b1111;
        target_locked = 4'b0000;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            n_vec++;
            if ({arb_state, launch_missile, fire_grant, remaining_missiles} !== {2'b00, 1'b0, 4'b0000, 4'd4}) begin
                n_err++; $display("FAIL unlocked[%0d]: got %b expected %b", t,
                                  {arb_state, launch_missile, fire_grant, remaining_missiles},
                                  {2'b00, 1'b0, 4'b0000, 4'd4});
            end
        end
        fire_req = 4'b0000;
    endtask

    task automatic test_reset_mid_cooldown();
        do_reset();
        fire_req      = 4'b0010;
        target_locked = 4'b0010;
        @(negedge clk);
        fire_req      = 4'b0000;
        target_locked = 4'b0000;
        n_vec++;
        if ({launch_missile, launch_ch} !== {1'b1, 2'd1}) begin
            n_err++; $display("FAIL midrst_launch: got %b expected %b", {launch_missile, launch_ch}, {1'b1, 2'd1});
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
        end
        n_vec++;
        if (arb_state !== 2'b10) begin
            n_err++; $display("FAIL midrst_in_cooldown: got %b expected 10", arb_state);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (snap() !== {2'b00, 1'b0, 4'b0000, 2'd0, 4'd4, 1'b0}) begin
            n_err++; $display("FAIL midrst_values: got %b expected %b", snap(),
                              {2'b00, 1'b0, 4'b0000, 2'd0, 4'd4, 1'b0});
        end
        // With rr_ptr back at 0, ch1 must beat ch2.
        fire_req      = 4'b0110;
        target_locked = 4'b0110;
        @(negedge clk);
        fire_req      = 4'b0000;
        target_locked = 4'b0000;
        n_vec++;
        if ({launch_missile, fire_grant, launch_ch} !== {1'b1, 4'b0010, 2'd1}) begin
            n_err++; $display("FAIL midrst_rr_ptr: got %b expected %b",
                              {launch_missile, fire_grant, launch_ch}, {1'b1, 4'b0010, 2'd1});
        end
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        fire_req      = 4'b1000;
        target_locked = 4'b1000;
        @(negedge clk);
        fire_req      = 4'b0000;
        target_locked = 4'b0000;
        n_vec++;
        if ({launch_missile, fire_grant, launch_ch} !== {1'b1, 4'b1000, 2'd3}) begin
            n_err++; $display("FAIL wrap_first: got %b expected %b",
                              {launch_missile, fire_grant, launch_ch}, {1'b1, 4'b1000, 2'd3});
        end
        repeat (11) @(negedge clk);
        fire_req      = 4'b1001;
        target_locked = 4'b1001;
        @(negedge clk);
        fire_req      = 4'b0000;
        target_locked = 4'b0000;
        n_vec++;
        if ({launch_missile, fire_grant, launch_ch, remaining_missiles} !== {1'b1, 4'b0001, 2'd0, 4'd2}) begin
            n_err++; $display("FAIL wrap_second: got %b expected %b",
                              {launch_missile, fire_grant, launch_ch, remaining_missiles},
                              {1'b1, 4'b0001, 2'd0, 4'd2});
        end
    endtask

`ifdef FIRE_ARB_RELOAD_EN
    task automatic test_reload();
        logic el;
        do_reset();
        fire_req      = 4'b0001;
        target_locked = 4'b0001;
        for (int t = 0; t <= 47; t++) begin
            @(negedge clk);
            el = (t <= 36) && (t % 12 == 0);
            n_vec++;
            if (launch_missile !== el) begin
                n_err++; $display("FAIL reload_drain[%0d]: got %b expected %b", t, launch_missile, el);
            end
        end
        n_vec++;
        if ({arb_state, remaining_missiles} !== {2'b11, 4'd0}) begin
            n_err++; $display("FAIL reload_empty: got %b expected %b", {arb_state, remaining_missiles}, {2'b11, 4'd0});
        end
        fire_req      = 4'b0000;
        target_locked = 4'b0000;
        reload        = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({arb_state, remaining_missiles} !== {2'b00, 4'd4}) begin
            n_err++; $display("FAIL reload_from_empty: got %b expected %b", {arb_state, remaining_missiles}, {2'b00, 4'd4});
        end
        fire_req      = 4'b1000;
        target_locked = 4'b1000;
        @(negedge clk);
        reload = 1'b0;
        n_vec++;
        if ({arb_state, launch_missile, remaining_missiles} !== {2'b00, 1'b0, 4'd4}) begin
            n_err++; $display("FAIL reload_priority: got %b expected %b",
                              {arb_state, launch_missile, remaining_missiles}, {2'b00, 1'b0, 4'd4});
        end
        @(negedge clk);
        fire_req      = 4'b0000;
        target_locked = 4'b0000;
        n_vec++;
        if ({launch_missile, fire_grant, launch_ch, remaining_missiles} !== {1'b1, 4'b1000, 2'd3, 4'd3}) begin
            n_err++; $display("FAIL reload_then_grant: got %b expected %b",
                              {launch_missile, fire_grant, launch_ch, remaining_missiles},
                              {1'b1, 4'b1000, 2'd3, 4'd3});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_launch();
        test_round_robin_to_empty();
        test_unlocked_requests();
        test_reset_mid_cooldown();
        test_pointer_wrap();
`ifdef FIRE_ARB_RELOAD_EN
        test_reload();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
